fp_unpacker: RTL and testbench

- Decodes packed IEEE-754 operands into the unpacked sign / 8-bit exponent / 23-bit mantissa form that the FP adder/subtractor and other arithmetic units consume.
- Covers both precisions:
  - Half: rebias to single bias 127, widen the mantissa, normalise subnormals iteratively.
  - Single: pass through.
- Also classifies each operand (zero/inf/NaN/sNaN/subnormal).
- Sits between the operand register file and the arithmetic datapath, using a valid/ready handshake on both sides.

---
 rtl/fp_unpacker_if.sv | 37 +++
 rtl/fp_unpacker.sv | 159 +++++++++++++++
 tb/tb_fp_unpacker.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_unpacker_if.sv
// Operand-side and result-side handshake bundle for fp_unpacker.
//   slave  : the unpacker (takes operands, produces unpacked results)
//   master : the producer/consumer pair driving and draining it
// Signals:
//   in_valid/in_ready/mode_fp/operand     operand handshake and payload
//   out_valid/out_ready                   result handshake
//   out_mode_fp/out_sign/out_exp/out_mant unpacked result
//   is_zero/is_inf/is_nan/is_snan/is_subnormal  operand classification
interface fp_unpacker_if;
    logic        in_valid;
    logic        in_ready;
    logic        mode_fp;
    logic [31:0] operand;
    logic        out_valid;
    logic        out_ready;
    logic        out_mode_fp;
    logic        out_sign;
    logic [7:0]  out_exp;
    logic [22:0] out_mant;
    logic        is_zero;
    logic        is_inf;
    logic        is_nan;
    logic        is_snan;
    logic        is_subnormal;

    modport slave (
        input  in_valid, mode_fp, operand, out_ready,
        output in_ready, out_valid, out_mode_fp, out_sign, out_exp, out_mant,
               is_zero, is_inf, is_nan, is_snan, is_subnormal
    );

    modport master (
        output in_valid, mode_fp, operand, out_ready,
        input  in_ready, out_valid, out_mode_fp, out_sign, out_exp, out_mant,
               is_zero, is_inf, is_nan, is_snan, is_subnormal
    );
endinterface

// File: rtl/fp_unpacker.sv
// Unpacks an IEEE-754 half or single operand into sign / 8-bit single-bias
// exponent / 23-bit fraction, plus zero/inf/NaN/sNaN/subnormal flags.
// Half subnormals are normalised one bit per cycle in StNorm.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-low reset
//   bus  fp_unpacker_if.slave (operand and result handshakes, result fields)
module fp_unpacker #(
    parameter int unsigned SP_EXP_BIAS = 127,
    parameter int unsigned HP_EXP_BIAS = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    fp_unpacker_if.slave         bus
);
    localparam logic [7:0] REBIAS = 8'(SP_EXP_BIAS - HP_EXP_BIAS);
    // A half subnormal has the exponent of e=1; the first shift brings it to REBIAS.
    localparam logic [7:0] SUB_START_EXP = REBIAS + 8'd1;

    typedef enum logic [1:0] {StIdle, StNorm, StHold} state_e;

    state_e      state_q, state_d;
    logic        mode_q, mode_d;
    logic        sign_q, sign_d;
    logic [7:0]  exp_q, exp_d;
    logic [22:0] mant_q, mant_d;
    logic        zero_q, zero_d;
    logic        inf_q, inf_d;
    logic        nan_q, nan_d;
    logic        snan_q, snan_d;
    logic        sub_q, sub_d;
    // Normalisation working registers, kept apart so outputs hold their old values in StNorm.
    logic [10:0] norm_m_q, norm_m_d;
    logic [7:0]  norm_e_q, norm_e_d;

    logic [7:0]  s_e;
    logic [22:0] s_f;
    logic [4:0]  h_e;
    logic [9:0]  h_f;

    assign s_e = bus.operand[30:23];
    assign s_f = bus.operand[22:0];
    assign h_e = bus.operand[14:10];
    assign h_f = bus.operand[9:0];

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        mant_d   = mant_q;
        zero_d   = zero_q;
        inf_d    = inf_q;
        nan_d    = nan_q;
        snan_d   = snan_q;
        sub_d    = sub_q;
        norm_m_d = norm_m_q;
        norm_e_d = norm_e_q;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    mode_d = bus.mode_fp;
                    if (bus.mode_fp) begin
                        sign_d  = bus.operand[31];
                        exp_d   = s_e;
                        mant_d  = s_f;
                        zero_d  = (s_e == 8'd0) && (s_f == 23'd0);
                        sub_d   = (s_e == 8'd0) && (s_f != 23'd0);
                        inf_d   = (&s_e) && (s_f == 23'd0);
                        nan_d   = (&s_e) && (s_f != 23'd0);
                        snan_d  = (&s_e) && (s_f != 23'd0) && !s_f[22];
                        state_d = StHold;
                    end else begin
                        sign_d = bus.operand[15];
                        zero_d = (h_e == 5'd0) && (h_f == 10'd0);
                        sub_d  = (h_e == 5'd0) && (h_f != 10'd0);
                        inf_d  = (&h_e) && (h_f == 10'd0);
                        nan_d  = (&h_e) && (h_f != 10'd0);
                        snan_d = (&h_e) && (h_f != 10'd0) && !h_f[9];
                        if ((h_e == 5'd0) && (h_f != 10'd0)) begin
                            norm_m_d = {1'b0, h_f};
                            norm_e_d = SUB_START_EXP;
                            state_d  = StNorm;
                        end else begin
                            mant_d = {h_f, 13'd0};
                            if (h_e == 5'd0) begin
                                exp_d = 8'd0;
                            end else if (&h_e) begin
                                exp_d = 8'hFF;
                            end else begin
                                exp_d = {3'd0, h_e} + REBIAS;
                            end
                            state_d = StHold;
                        end
                    end
                end
            end
            StNorm: begin
                norm_m_d = {norm_m_q[9:0], 1'b0};
                norm_e_d = norm_e_q - 8'd1;
                // Stop once the leading one reaches the implicit-bit position.
                if (norm_m_d[10]) begin
                    exp_d   = norm_e_d;
                    mant_d  = {norm_m_d[9:0], 13'd0};
                    state_d = StHold;
                end
            end
            StHold: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            mode_q   <= 1'b0;
            sign_q   <= 1'b0;
            exp_q    <= 8'd0;
            mant_q   <= 23'd0;
            zero_q   <= 1'b0;
            inf_q    <= 1'b0;
            nan_q    <= 1'b0;
            snan_q   <= 1'b0;
            sub_q    <= 1'b0;
            norm_m_q <= 11'd0;
            norm_e_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            mant_q   <= mant_d;
            zero_q   <= zero_d;
            inf_q    <= inf_d;
            nan_q    <= nan_d;
            snan_q   <= snan_d;
            sub_q    <= sub_d;
            norm_m_q <= norm_m_d;
            norm_e_q <= norm_e_d;
        end
    end

    assign bus.in_ready     = (state_q == StIdle);
    assign bus.out_valid    = (state_q == StHold);
    assign bus.out_mode_fp  = mode_q;
    assign bus.out_sign     = sign_q;
    assign bus.out_exp      = exp_q;
    assign bus.out_mant     = mant_q;
    assign bus.is_zero      = zero_q;
    assign bus.is_inf       = inf_q;
    assign bus.is_nan       = nan_q;
    assign bus.is_snan      = snan_q;
    assign bus.is_subnormal = sub_q;
endmodule

// File: tb/tb_fp_unpacker.sv
// Self-checking bench for fp_unpacker: directed vector table, backpressure and
// mid-normalisation reset sequences, then random operands against a value-level model.
module tb_fp_unpacker;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fp_unpacker_if bus();

    fp_unpacker #(
        .SP_EXP_BIAS(127),
        .HP_EXP_BIAS(15)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // flags = {zero, inf, nan, snan, subnormal}
    typedef struct {
        logic        mode;
        logic [31:0] op;
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
        logic [4:0]  flags;
        int          lat;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [4:0] cur_flags();
        return {bus.is_zero, bus.is_inf, bus.is_nan, bus.is_snan, bus.is_subnormal};
    endfunction

    // Value-level reference: a half subnormal f*2^-24 with leading one at bit p
    // has true exponent p-24, and one normalisation cycle per bit moved.
    function automatic vec_t model(input logic mode, input logic [31:0] op);
        vec_t r;
        int e, f, p;
        r.mode = mode; r.op = op; r.flags = 5'd0; r.lat = 1;
        if (mode) begin
            e = int'(op[30:23]); f = int'(op[22:0]);
            r.sign = op[31]; r.exp = 8'(e); r.mant = 23'(f);
            if (e == 0) r.flags = (f == 0) ? 5'b10000 : 5'b00001;
            else if (e == 255) begin
                if (f == 0) r.flags = 5'b01000;
                else r.flags = (f < (1 << 22)) ? 5'b00110 : 5'b00100;
            end
        end else begin
            e = int'(op[14:10]); f = int'(op[9:0]);
            r.sign = op[15];
            if (e == 0 && f == 0) begin
                r.exp = 8'd0; r.mant = 23'd0; r.flags = 5'b10000;
            end else if (e == 0) begin
                p = 0;
                for (int i = 0; i < 10; i++) if ((f >> i) & 1) p = i;
                r.exp = 8'(p - 24 + 127);
                r.mant = 23'((f - (1 << p)) << (23 - p));
                r.flags = 5'b00001;
                r.lat = 1 + (10 - p);
            end else if (e == 31) begin
                r.exp = 8'hFF; r.mant = 23'(f << 13);
                if (f == 0) r.flags = 5'b01000;
                else r.flags = (f < 512) ? 5'b00110 : 5'b00100;
            end else begin
                r.exp = 8'(e - 15 + 127); r.mant = 23'(f << 13);
            end
        end
        return r;
    endfunction

    // Present one operand, accept it, then wait (bounded) for out_valid. Ends at a negedge.
    task automatic start(input logic mode, input logic [31:0] op, output int lat);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.mode_fp = mode; bus.operand = op;
        chk("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0; bus.operand = $urandom; bus.mode_fp = 1'($urandom);
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_res(input string tag, input vec_t v, input int lat);
        chk($sformatf("%s.out_valid", tag), 32'(bus.out_valid), 32'd1);
        chk($sformatf("%s.latency", tag), 32'(lat), 32'(v.lat));
        chk($sformatf("%s.mode", tag), 32'(bus.out_mode_fp), 32'(v.mode));
        chk($sformatf("%s.sign", tag), 32'(bus.out_sign), 32'(v.sign));
        chk($sformatf("%s.exp", tag), 32'(bus.out_exp), 32'(v.exp));
        chk($sformatf("%s.mant", tag), 32'(bus.out_mant), 32'(v.mant));
        chk($sformatf("%s.flags", tag), 32'(cur_flags()), 32'(v.flags));
    endtask

    // Called at a negedge while out_valid is high.
    task automatic release_out(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk($sformatf("%s.valid_drop", tag), 32'(bus.out_valid), 32'd0);
        chk($sformatf("%s.ready_back", tag), 32'(bus.in_ready), 32'd1);
    endtask

    task automatic check_reset_state(input string tag);
        chk($sformatf("%s.in_ready", tag), 32'(bus.in_ready), 32'd1);
        chk($sformatf("%s.out_valid", tag), 32'(bus.out_valid), 32'd0);
        chk($sformatf("%s.data", tag),
            {bus.out_mode_fp, bus.out_sign, bus.out_exp, bus.out_mant}, 32'd0);
        chk($sformatf("%s.flags", tag), 32'(cur_flags()), 32'd0);
    endtask

    initial begin
        vec_t vecs[$];
        vec_t v;
        int   lat;
        int   d;
        logic [31:0] op;
        logic mode;

        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        vec_t v;
        int   lat;
        int   d;
        logic [31:0] op;
        logic [22:0] held_mant;
        logic        mode;

        bus.in_valid = 1'b0; bus.mode_fp = 1'b0; bus.operand = 32'd0; bus.out_ready = 1'b0;

        //                mode  operand        sign exp    mant        flags    lat
        vecs.push_back('{1'b1, 32'h3F80_0000, 1'b0, 8'h7F, 23'h000000, 5'b00000, 1});
        vecs.push_back('{1'b1, 32'hC000_0000, 1'b1, 8'h80, 23'h000000, 5'b00000, 1});
        vecs.push_back('{1'b0, 32'h0000_3C00, 1'b0, 8'h7F, 23'h000000, 5'b00000, 1});
        vecs.push_back('{1'b0, 32'hFFFF_C000, 1'b1, 8'h80, 23'h000000, 5'b00000, 1});
        vecs.push_back('{1'b0, 32'h0000_0001, 1'b0, 8'h67, 23'h000000, 5'b00001, 11});
        vecs.push_back('{1'b0, 32'h0000_0200, 1'b0, 8'h70, 23'h000000, 5'b00001, 2});
        vecs.push_back('{1'b0, 32'h0000_0300, 1'b0, 8'h70, 23'h400000, 5'b00001, 2});
        vecs.push_back('{1'b0, 32'h0000_7C00, 1'b0, 8'hFF, 23'h000000, 5'b01000, 1});
        vecs.push_back('{1'b0, 32'h0000_7D00, 1'b0, 8'hFF, 23'h200000, 5'b00110, 1});
        vecs.push_back('{1'b0, 32'h0000_7E00, 1'b0, 8'hFF, 23'h400000, 5'b00100, 1});
        vecs.push_back('{1'b0, 32'h0000_8000, 1'b1, 8'h00, 23'h000000, 5'b10000, 1});
        vecs.push_back('{1'b1, 32'h0000_0001, 1'b0, 8'h00, 23'h000001, 5'b00001, 1});
        vecs.push_back('{1'b1, 32'h7F80_0001, 1'b0, 8'hFF, 23'h000001, 5'b00110, 1});
        vecs.push_back('{1'b1, 32'hFFC0_0000, 1'b1, 8'hFF, 23'h400000, 5'b00100, 1});
        vecs.push_back('{1'b1, 32'h8000_0000, 1'b1, 8'h00, 23'h000000, 5'b10000, 1});

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("after_reset");

        // Directed table
        for (int i = 0; i < vecs.size(); i++) begin
            start(vecs[i].mode, vecs[i].op, lat);
            check_res($sformatf("vec%0d", i), vecs[i], lat);
            release_out($sformatf("vec%0d", i));
        end

        // Backpressure: result held, new operand refused until release
        start(1'b1, 32'h3F80_0000, lat);
        bus.in_valid = 1'b1; bus.mode_fp = 1'b1; bus.operand = 32'h4000_0000;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp.out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp.in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp.exp", 32'(bus.out_exp), 32'h7F);
            chk("bp.mant", 32'(bus.out_mant), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("bp.released_valid", 32'(bus.out_valid), 32'd0);
        chk("bp.released_ready", 32'(bus.in_ready), 32'd1);
        chk("bp.old_exp_kept", 32'(bus.out_exp), 32'h7F);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("bp.new_valid", 32'(bus.out_valid), 32'd1);
        chk("bp.new_exp", 32'(bus.out_exp), 32'h80);
        chk("bp.new_mant", 32'(bus.out_mant), 32'd0);
        release_out("bp");

        // Reset during normalisation of half 0x0001
        @(negedge clk);
        bus.in_valid = 1'b1; bus.mode_fp = 1'b0; bus.operand = 32'h0000_0001;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rstnorm.busy", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        check_reset_state("rstnorm");
        start(1'b1, 32'h3F80_0000, lat);
        check_res("post_reset", vecs[0], lat);
        release_out("post_reset");

        // Random operands against the model, with random consumer stalls
        for (int n = 0; n < 80; n++) begin
            mode = 1'($urandom);
            op = $urandom;
            d = $urandom_range(0, 5);
            if (d < 2) begin
                if (mode) op[30:23] = 8'd0; else op[14:10] = 5'd0;
            end else if (d == 2) begin
                if (mode) op[30:23] = 8'hFF; else op[14:10] = 5'h1F;
            end
            v = model(mode, op);
            start(mode, op, lat);
            check_res($sformatf("rnd%0d", n), v, lat);
            held_mant = bus.out_mant;
            d = $urandom_range(0, 3);
            for (int c = 0; c < d; c++) @(negedge clk);
            chk($sformatf("rnd%0d.held", n), 32'(bus.out_mant), 32'(v.mant));
            release_out($sformatf("rnd%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
